hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage datapath (Fetch/Decode/Execute/Memory/Writeback).
- Keeps its own shadow pipeline of destination-register and control tags for E, M and W.
- From these tags it produces forwarding selects for the Execute-stage ALU operands, plus stall and flush enables for the F/D/E pipeline registers.
- Handles load-use stalls, PC-write bubbles and taken-branch flushes.
- Sits beside the datapath; the datapath's pipeline registers gain enable/clear inputs driven from here.

---
 rtl/hazard_pkg.sv | 49 ++++
 rtl/hazard_tag_stage.sv | 26 ++
 rtl/hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
// Holds the forwarding-select encodings, the default register-address width,
// the PC alias index, and the shadow tag carried through the E/M/W stages.
package hazard_pkg;

   // Default register-file address width and the index that aliases the PC.
   localparam int                        REG_ADDR_W_DEF = 4;
   localparam logic [REG_ADDR_W_DEF-1:0] PC_REG_DEF     = 4'd15;

   // Execute-stage operand source selects.
   localparam logic [1:0] FWD_RF  = 2'b00;  // value read from the register file
   localparam logic [1:0] FWD_WB  = 2'b01;  // ResultW
   localparam logic [1:0] FWD_MEM = 2'b10;  // ALUOutM

   // Shadow copy of the control fields of one pipeline stage. The read
   // addresses are only meaningful in E; later stages carry them as zero.
   // Address fields are sized by REG_ADDR_W_DEF, so the top-level
   // REG_ADDR_W parameter is expected to stay at this default.
   typedef struct packed {
      logic                      valid;
      logic [REG_ADDR_W_DEF-1:0] wa3;
      logic                      regWrite;
      logic                      memToReg;
      logic                      pcWrite;
      logic [REG_ADDR_W_DEF-1:0] ra1;
      logic [REG_ADDR_W_DEF-1:0] ra2;
   } shadowTag_t;

   // Pick the operand source for one Execute read address. M wins over W,
   // and the PC alias is never forwarded.
   function automatic logic [1:0] fwdSelect(
      input shadowTag_t                tagM,
      input shadowTag_t                tagW,
      input logic [REG_ADDR_W_DEF-1:0] src,
      input logic [REG_ADDR_W_DEF-1:0] pcReg
   );
      logic [1:0] sel;
      sel = FWD_RF;
      if (src != pcReg) begin
         if (tagM.valid && tagM.regWrite && (tagM.wa3 == src)) begin
            sel = FWD_MEM;
         end else if (tagW.valid && tagW.regWrite && (tagW.wa3 == src)) begin
            sel = FWD_WB;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/hazard_tag_stage.sv
// hazard_tag_stage: one shadow pipeline register holding a stage's control tag.
// Synchronous active-low reset clears the tag; bubble inserts an invalid
// (all-zero) tag; otherwise the tag loads when enabled.
module hazard_tag_stage
   import hazard_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       bubble,
   input  shadowTag_t nextTag,
   output shadowTag_t tag
);

   // Tag register: reset and bubble both yield an empty slot, bubble beats load.
   always_ff @(posedge clk) begin
      if (!reset) begin
         tag <= '0;
      end else if (bubble) begin
         tag <= '0;
      end else if (enable) begin
         tag <= nextTag;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard controller for the five-stage F/D/E/M/W pipeline.
// Tracks destination/control tags for E, M and W in a shadow pipeline and
// derives the Execute operand forwarding selects plus stall/flush enables
// for the F/D/E pipeline registers (load-use stalls, PC-write bubbles,
// taken-branch flushes).
// Optional build macro HAZARD_PERF_CNT_EN adds saturating 32-bit counters
// stall_cycles and flush_cycles.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int                    REG_ADDR_W = REG_ADDR_W_DEF,
   parameter logic [REG_ADDR_W-1:0] PC_REG     = PC_REG_DEF
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_d,
   input  logic [REG_ADDR_W-1:0] ra1_d,
   input  logic [REG_ADDR_W-1:0] ra2_d,
   input  logic [REG_ADDR_W-1:0] wa3_d,
   input  logic                  regwrite_d,
   input  logic                  memtoreg_d,
   input  logic                  pcwrite_d,
   input  logic                  branch_taken_e,
   output logic [1:0]            fwd_a_e,
   output logic [1:0]            fwd_b_e,
   output logic                  stall_f,
   output logic                  stall_d,
   output logic                  flush_d,
   output logic                  flush_e
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]           stall_cycles,
   output logic [31:0]           flush_cycles
`endif
);

   shadowTag_t tagD;
   shadowTag_t tagE;
   shadowTag_t tagM;
   shadowTag_t tagW;
   shadowTag_t tagEtoM;

   logic [1:0] fwdA;
   logic [1:0] fwdB;
   logic       ldStall;
   logic       pcWritePend;
   logic       bubbleE;
   logic       unusedTagBits;

   // Capture the Decode instruction's tags in shadow-tag form.
   always_comb begin
      tagD          = '0;
      tagD.valid    = valid_d;
      tagD.wa3      = wa3_d;
      tagD.regWrite = regwrite_d;
      tagD.memToReg = memtoreg_d;
      tagD.pcWrite  = pcwrite_d;
      tagD.ra1      = ra1_d;
      tagD.ra2      = ra2_d;
   end

   // Read addresses only matter in E, so they are dropped on the way to M.
   always_comb begin
      tagEtoM     = tagE;
      tagEtoM.ra1 = '0;
      tagEtoM.ra2 = '0;
   end

   // E is bubbled whenever Execute gets cleared or Decode is held. This uses
   // the raw hazard terms; reset clears every stage on its own.
   assign bubbleE = ldStall | branch_taken_e;

   hazard_tag_stage u_stage_e (
      .clk     (clk),
      .reset   (reset),
      .enable  (1'b1),
      .bubble  (bubbleE),
      .nextTag (tagD),
      .tag     (tagE)
   );

   hazard_tag_stage u_stage_m (
      .clk     (clk),
      .reset   (reset),
      .enable  (1'b1),
      .bubble  (1'b0),
      .nextTag (tagEtoM),
      .tag     (tagM)
   );

   hazard_tag_stage u_stage_w (
      .clk     (clk),
      .reset   (reset),
      .enable  (1'b1),
      .bubble  (1'b0),
      .nextTag (tagM),
      .tag     (tagW)
   );

   // W's read addresses and load flag never feed any decision.
   assign unusedTagBits = ^{tagW.ra1, tagW.ra2, tagW.memToReg};

   // Hazard detection from shadow state and the live Decode inputs.
   always_comb begin
      fwdA = fwdSelect(tagM, tagW, tagE.ra1, PC_REG);
      fwdB = fwdSelect(tagM, tagW, tagE.ra2, PC_REG);

      // A load in E whose destination Decode wants to read: one bubble.
      ldStall = tagE.valid & tagE.memToReg & tagE.regWrite & valid_d
              & (tagE.wa3 != PC_REG)
              & ((tagE.wa3 == ra1_d) | (tagE.wa3 == ra2_d));

      // A PC write anywhere from Decode through Memory keeps Fetch frozen.
      pcWritePend = (valid_d & pcwrite_d)
                  | (tagE.valid & tagE.pcWrite)
                  | (tagM.valid & tagM.pcWrite);
   end

   // Drive the pipeline controls; during reset the pipe is held flushed.
   always_comb begin
      fwd_a_e = fwdA;
      fwd_b_e = fwdB;
      stall_f = ldStall | pcWritePend;
      stall_d = ldStall;
      flush_d = pcWritePend | (tagW.valid & tagW.pcWrite) | branch_taken_e;
      flush_e = ldStall | branch_taken_e;
      if (!reset) begin
         fwd_a_e = FWD_RF;
         fwd_b_e = FWD_RF;
         stall_f = 1'b0;
         stall_d = 1'b0;
         flush_d = 1'b1;
         flush_e = 1'b1;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   // Saturating counts of Decode-stall cycles and Execute-flush cycles.
   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_cycles <= '0;
         flush_cycles <= '0;
      end else begin
         if (stall_d && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
         if (flush_e && (flush_cycles != 32'hFFFF_FFFF)) begin
            flush_cycles <= flush_cycles + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed-vector bench for hazard_ctrl. Each vector drives
// one cycle of Decode/Execute inputs and queues the hand-computed outputs
// {fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e}; a monitor on the
// falling edge pops and compares them.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       valid_d = 1'b0;
   logic [3:0] ra1_d = '0;
   logic [3:0] ra2_d = '0;
   logic [3:0] wa3_d = '0;
   logic       regwrite_d = 1'b0;
   logic       memtoreg_d = 1'b0;
   logic       pcwrite_d = 1'b0;
   logic       branch_taken_e = 1'b0;
   logic [1:0] fwd_a_e;
   logic [1:0] fwd_b_e;
   logic       stall_f;
   logic       stall_d;
   logic       flush_d;
   logic       flush_e;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cycles;
   logic [31:0] flush_cycles;
`endif

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] exp_q[$];
   int         id_q[$];
   logic [7:0] mon_exp;
   logic [7:0] mon_act;
   int         mon_id;

   hazard_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .valid_d        (valid_d),
      .ra1_d          (ra1_d),
      .ra2_d          (ra2_d),
      .wa3_d          (wa3_d),
      .regwrite_d     (regwrite_d),
      .memtoreg_d     (memtoreg_d),
      .pcwrite_d      (pcwrite_d),
      .branch_taken_e (branch_taken_e),
      .fwd_a_e        (fwd_a_e),
      .fwd_b_e        (fwd_b_e),
      .stall_f        (stall_f),
      .stall_d        (stall_d),
      .flush_d        (flush_d),
      .flush_e        (flush_e)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_cycles   (stall_cycles),
      .flush_cycles   (flush_cycles)
`endif
   );

   // Clock.
   always #5 clk = ~clk;

   // Watchdog.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
      $fatal(1, "watchdog expired");
   end

   // Drive one cycle of inputs just after the rising edge and queue its expectation.
   task automatic apply(input int id, input logic rst, input logic vd,
                        input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] w,
                        input logic rw, input logic mr, input logic pw, input logic bt,
                        input logic [7:0] exp_val);
      @(posedge clk);
      #1;
      reset          = rst;
      valid_d        = vd;
      ra1_d          = r1;
      ra2_d          = r2;
      wa3_d          = w;
      regwrite_d     = rw;
      memtoreg_d     = mr;
      pcwrite_d      = pw;
      branch_taken_e = bt;
      exp_q.push_back(exp_val);
      id_q.push_back(id);
   endtask

   // Monitor: compare the combinational outputs mid-cycle against the queue head.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         mon_id  = id_q.pop_front();
         mon_act = {fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e};
         vectors++;
         if (mon_act !== mon_exp) begin
            miscompares++;
            $display("FAIL vec%0d {fwdA,fwdB,sf,sd,fd,fe}: got %b_%b_%b%b%b%b required %b_%b_%b%b%b%b",
                     mon_id, mon_act[7:6], mon_act[5:4], mon_act[3], mon_act[2], mon_act[1], mon_act[0],
                     mon_exp[7:6], mon_exp[5:4], mon_exp[3], mon_exp[2], mon_exp[1], mon_exp[0]);
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   task automatic check_counters(input string name, input logic [31:0] exp_stall,
                                 input logic [31:0] exp_flush);
      @(negedge clk);
      #1;
      vectors++;
      if ((stall_cycles !== exp_stall) || (flush_cycles !== exp_flush)) begin
         miscompares++;
         $display("FAIL %s perf counters: got stall=%0d flush=%0d required stall=%0d flush=%0d",
                  name, stall_cycles, flush_cycles, exp_stall, exp_flush);
      end
   endtask
`endif

   // Directed vectors. Fields: id, reset, valid, ra1, ra2, wa3, regwrite,
   // memtoreg, pcwrite, branch_taken, expected {fwdA,fwdB,sf,sd,fd,fe}.
   initial begin
      // Reset: outputs forced to no forwarding, no stall, full flush.
      apply( 0, 0, 0,  0,  0,  0, 0, 0, 0, 0, 8'b00_00_0011);
      apply( 1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 8'b00_00_0011);
      // ADD r1,r7,r8: first cycle after reset, nothing in flight.
      apply( 2, 1, 1,  7,  8,  1, 1, 0, 0, 0, 8'b00_00_0000);
      // SUB r9,r1,r10 in D; ADD in E.
      apply( 3, 1, 1,  1, 10,  9, 1, 0, 0, 0, 8'b00_00_0000);
      // AND r11,r1,r12 in D; SUB in E with r1 in M -> fwdA=10.
      apply( 4, 1, 1,  1, 12, 11, 1, 0, 0, 0, 8'b10_00_0000);
      // ORR r3,r9,r11 in D; AND in E, r1 in W, M writes r9 -> fwdA=01.
      apply( 5, 1, 1,  9, 11,  3, 1, 0, 0, 0, 8'b01_00_0000);
      // LDR r2 in D; ORR in E: r9 from W, r11 from M.
      apply( 6, 1, 1, 11,  9,  2, 1, 1, 0, 0, 8'b01_10_0000);
      // ADD r3,r2,r4 in D; LDR r2 in E -> load-use stall.
      apply( 7, 1, 1,  2,  4,  3, 1, 0, 0, 0, 8'b01_00_1101);
      // ADD held in D, bubble in E: no stall.
      apply( 8, 1, 1,  2,  4,  3, 1, 0, 0, 0, 8'b00_00_0000);
      // ADD in E, load in W -> fwdA=01.
      apply( 9, 1, 0,  0,  0,  0, 0, 0, 0, 0, 8'b01_00_0000);
      // B (PC write) in D at n: stall_f n..n+2, flush_d n..n+3.
      apply(10, 1, 1,  0,  0, 15, 0, 0, 1, 0, 8'b00_00_1010);
      apply(11, 1, 0,  0,  0,  0, 0, 0, 0, 0, 8'b00_00_1010);
      apply(12, 1, 0,  0,  0,  0, 0, 0, 0, 0, 8'b00_00_1010);
      apply(13, 1, 0,  0,  0,  0, 0, 0, 0, 0, 8'b00_00_0010);
      apply(14, 1, 0,  0,  0,  0, 0, 0, 0, 0, 8'b00_00_0000);
      // LDR r5 in D.
      apply(15, 1, 1,  1,  0,  5, 1, 1, 0, 0, 8'b00_00_0000);
      // ADD r6,r5,r7 in D with branch taken: flush wins over the stall.
      apply(16, 1, 1,  5,  7,  6, 1, 0, 0, 1, 8'b00_00_1111);
      // Decode cleared, E bubbled: stall_d back to 0.
      apply(17, 1, 0,  0,  0,  0, 0, 0, 0, 0, 8'b00_00_0000);
      // MOV r15 (writes the PC) in D.
      apply(18, 1, 1,  1,  2, 15, 1, 0, 1, 0, 8'b00_00_1010);
      // ADD r8,r15,r6 in D; MOV in E.
      apply(19, 1, 1, 15,  6,  8, 1, 0, 0, 0, 8'b00_00_1010);
      // ADD reads R15 while M writes r15: never forwarded.
      apply(20, 1, 0,  0,  0,  0, 0, 0, 0, 0, 8'b00_00_1010);
      // Two ADD r6 back to back, then SUB r9,r6,r6.
      apply(21, 1, 1,  0,  0,  6, 1, 0, 0, 0, 8'b00_00_0010);
      apply(22, 1, 1,  0,  0,  6, 1, 0, 0, 0, 8'b00_00_0000);
      apply(23, 1, 1,  6,  6,  9, 1, 0, 0, 0, 8'b00_00_0000);
      // M and W both write r6: M wins on both operands.
      apply(24, 1, 0,  0,  0,  0, 0, 0, 0, 0, 8'b10_10_0000);
      // LDR r4 in D, then ADD r7,r3,r4: stall via the second operand.
      apply(25, 1, 1,  0,  0,  4, 1, 1, 0, 0, 8'b00_00_0000);
      apply(26, 1, 1,  3,  4,  7, 1, 0, 0, 0, 8'b00_00_1101);
      apply(27, 1, 1,  3,  4,  7, 1, 0, 0, 0, 8'b00_00_0000);
      // LDR r5 in D; ADD r7 in E reads r4 from W -> fwdB=01.
      apply(28, 1, 1,  0,  0,  5, 1, 1, 0, 0, 8'b00_01_0000);
`ifdef HAZARD_PERF_CNT_EN
      check_counters("after_stalls", 32'd3, 32'd3);
`endif
      // SUB r1,r5,r5 would stall, but reset is held for 2 cycles.
      apply(29, 0, 1,  5,  5,  1, 1, 0, 0, 0, 8'b00_00_0011);
      apply(30, 0, 1,  5,  5,  1, 1, 0, 0, 0, 8'b00_00_0011);
      // After release: shadow stages empty, no stall, no forwarding.
      apply(31, 1, 1,  5,  5,  1, 1, 0, 0, 0, 8'b00_00_0000);
`ifdef HAZARD_PERF_CNT_EN
      check_counters("after_reset", 32'd0, 32'd0);
`endif
      apply(32, 1, 0,  0,  0,  0, 0, 0, 0, 0, 8'b00_00_0000);

      // Let the monitor drain the queue.
      repeat (3) @(posedge clk);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d unconsumed expectations required 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
